add_sub_mod_pipe: RTL and testbench

ADD_SUB_MOD_PIPE -- requirements
Module: add_sub_mod_pipe

---
 rtl/zprize_param.sv | 19 +
 rtl/limb_add_pipe.sv | 59 +++++
 rtl/add_sub_mod_pipe.sv | 130 +++++++++++++
 tb/tb_add_sub_mod_pipe.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zprize_param.sv
// Shared ZPrize field-arithmetic parameters: op encoding and the BLS12-377 base-field prime.
package zprize_param;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_DBL = 2'd2,
      OP_NEG = 2'd3
   } op_e;

   localparam logic [377:0] P_BLS12_377 =
      378'h1ae3a4617c510eac63b05c06ca1493b1a22d9f300f5138f1ef3622fba094800170b5d44300000008508c00000000001;

   // SUB and NEG form a difference, so they are corrected by adding p back.
   function automatic logic op_is_sub(op_e op);
      return (op == OP_SUB) || (op == OP_NEG);
   endfunction

endpackage

// File: rtl/limb_add_pipe.sv
// Limb-segmented pipelined adder: limb k is summed in stage k with the carry registered by stage k-1.
// Operands are captured together; sum_o/cout_o appear NLIMB enabled cycles later.
module limb_add_pipe #(
   parameter int WIDTH  = 378,
   parameter int LIMB_W = 27
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic [WIDTH-1:0] x_i,
   input  logic [WIDTH-1:0] y_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int NLIMB = (WIDTH + LIMB_W - 1) / LIMB_W;

   for (genvar s = 0; s < NLIMB; s++) begin : g_st
      localparam int LO  = s * LIMB_W;
      localparam int REM = WIDTH - LO;
      localparam int LW  = (REM < LIMB_W) ? REM : LIMB_W;

      logic [REM-1:0]   xr, yr;
      logic             cr;
      logic [LW:0]      limb;
      logic [LO+LW-1:0] sum_q;
      logic             c_q;

      assign limb = {1'b0, xr[LW-1:0]} + {1'b0, yr[LW-1:0]} + {{LW{1'b0}}, cr};

      if (s == 0) begin : g_src
         assign xr = x_i;
         assign yr = y_i;
         assign cr = cin_i;
         always_ff @(posedge clk) if (en_i) sum_q <= limb[LW-1:0];
      end else begin : g_src
         assign xr = g_st[s-1].g_fwd.x_q;
         assign yr = g_st[s-1].g_fwd.y_q;
         assign cr = g_st[s-1].c_q;
         always_ff @(posedge clk) if (en_i) sum_q <= {limb[LW-1:0], g_st[s-1].sum_q};
      end

      always_ff @(posedge clk) if (en_i) c_q <= limb[LW];

      // Only the not-yet-summed upper limbs ride forward.
      if (s < NLIMB - 1) begin : g_fwd
         logic [REM-LW-1:0] x_q, y_q;
         always_ff @(posedge clk)
            if (en_i) begin
               x_q <= xr[REM-1:LW];
               y_q <= yr[REM-1:LW];
            end
      end
   end

   assign sum_o  = g_st[NLIMB-1].sum_q;
   assign cout_o = g_st[NLIMB-1].c_q;

endmodule

// File: rtl/add_sub_mod_pipe.sv
// Pipelined modular ADD/SUB/DBL/NEG over p = MODULUS: raw adder, correction adder, per-limb select.
// Define ADD_SUB_MOD_RANGE_CHK_EN to add out_err, flagging operands not reduced below p.
module add_sub_mod_pipe
   import zprize_param::*;
#(
   parameter int               WIDTH   = 378,
   parameter int               LIMB_W  = 27,
   parameter logic [WIDTH-1:0] MODULUS = WIDTH'(P_BLS12_377),
   parameter int               TAG_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
   output logic             out_err,
`endif
   output logic             idle
);

   localparam int NLIMB = (WIDTH + LIMB_W - 1) / LIMB_W;
   localparam int LAT   = 2 * NLIMB + 2;

   logic                        adv;
   logic [LAT-1:0]              vld_q;
   logic [2*NLIMB-1:0][1:0]     op_q;
   logic [LAT-1:0][TAG_W-1:0]   tag_q;

   assign adv       = !out_valid | out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[LAT-1];
   assign out_tag   = tag_q[LAT-1];
   assign idle      = !(|vld_q) && !in_valid;

   always_ff @(posedge clk or posedge rst)
      if (rst)      vld_q <= '0;
      else if (adv) vld_q <= {vld_q[LAT-2:0], in_valid};

   always_ff @(posedge clk)
      if (adv) begin
         op_q  <= {op_q[2*NLIMB-2:0], in_op};
         tag_q <= {tag_q[LAT-2:0], in_tag};
      end

   // SUB/NEG are a + ~b + 1 style, so carry-out 1 means no borrow.
   op_e              op_in;
   logic [WIDTH-1:0] a1_x, a1_y;
   logic             a1_cin;

   always_comb begin
      op_in  = op_e'(in_op);
      a1_x   = in_a;
      a1_y   = in_b;
      a1_cin = 1'b0;
      case (op_in)
         OP_SUB:  begin a1_y = ~in_b; a1_cin = 1'b1; end
         OP_DBL:  a1_y = in_a;
         OP_NEG:  begin a1_x = '0; a1_y = ~in_a; a1_cin = 1'b1; end
         default: ;
      endcase
   end

   logic [WIDTH-1:0] raw_lo, corr;
   logic             raw_hi, c2, sub_mid, sub_end, sel;

   limb_add_pipe #(.WIDTH(WIDTH), .LIMB_W(LIMB_W)) u_raw (
      .clk(clk), .en_i(adv), .x_i(a1_x), .y_i(a1_y), .cin_i(a1_cin),
      .sum_o(raw_lo), .cout_o(raw_hi)
   );

   assign sub_mid = op_is_sub(op_e'(op_q[NLIMB-1]));

   limb_add_pipe #(.WIDTH(WIDTH), .LIMB_W(LIMB_W)) u_corr (
      .clk(clk), .en_i(adv), .x_i(raw_lo), .y_i(sub_mid ? MODULUS : ~MODULUS), .cin_i(!sub_mid),
      .sum_o(corr), .cout_o(c2)
   );

   // Raw value waits alongside the correction adder.
   logic [NLIMB-1:0][WIDTH:0] raw_dq;
   logic [WIDTH:0]            raw_e;

   always_ff @(posedge clk)
      if (adv) raw_dq <= {raw_dq[NLIMB-2:0], {raw_hi, raw_lo}};

   assign raw_e   = raw_dq[NLIMB-1];
   assign sub_end = op_is_sub(op_e'(op_q[2*NLIMB-1]));
   assign sel     = sub_end ? !raw_e[WIDTH] : (raw_e[WIDTH] | c2);

   logic [NLIMB-1:0] sel_q;
   logic [WIDTH-1:0] raw_q, corr_q, out_d, out_data_q;

   always_ff @(posedge clk)
      if (adv) begin
         sel_q  <= {NLIMB{sel}};
         raw_q  <= raw_e[WIDTH-1:0];
         corr_q <= corr;
      end

   for (genvar k = 0; k < NLIMB; k++) begin : g_out
      localparam int LO = k * LIMB_W;
      localparam int LW = (WIDTH - LO < LIMB_W) ? (WIDTH - LO) : LIMB_W;
      assign out_d[LO +: LW] = sel_q[k] ? corr_q[LO +: LW] : raw_q[LO +: LW];
   end

   always_ff @(posedge clk)
      if (adv) out_data_q <= out_d;

   assign out_data = out_data_q;

`ifdef ADD_SUB_MOD_RANGE_CHK_EN
   logic           err_in;
   logic [LAT-1:0] err_q;

   assign err_in = (in_a >= MODULUS) || (((op_in == OP_ADD) || (op_in == OP_SUB)) && (in_b >= MODULUS));

   always_ff @(posedge clk)
      if (adv) err_q <= {err_q[LAT-2:0], err_in};

   assign out_err = err_q[LAT-1];
`endif

endmodule

// File: tb/tb_add_sub_mod_pipe.sv
// Bench for add_sub_mod_pipe: small 16-bit instance (p=65521) plus a default-parameter instance.
module tb_add_sub_mod_pipe;
   import zprize_param::*;

   localparam int W = 16, LW = 4, TW = 8, P = 65521, LAT = 10;
   localparam int DW = 378, DLAT = 30;
   localparam logic [DW-1:0] PD = P_BLS12_377;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, out_valid, out_ready, idle;
   logic [1:0]    in_op;
   logic [W-1:0]  in_a, in_b, out_data;
   logic [TW-1:0] in_tag, out_tag;

   logic          d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_idle;
   logic [1:0]    d_in_op;
   logic [DW-1:0] d_in_a, d_in_b, d_out_data;
   logic [TW-1:0] d_in_tag, d_out_tag;
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
   logic          out_err, d_out_err;
`endif

   add_sub_mod_pipe #(.WIDTH(W), .LIMB_W(LW), .MODULUS(16'(P)), .TAG_W(TW)) u_small (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag),
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
      .out_err(out_err),
`endif
      .idle(idle)
   );

   add_sub_mod_pipe u_dflt (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
      .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
      .out_data(d_out_data), .out_tag(d_out_tag),
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
      .out_err(d_out_err),
`endif
      .idle(d_idle)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Field arithmetic straight from the operation definitions.
   function automatic int model(input logic [1:0] op, input int a, input int b);
      case (op)
         2'd0:    return (a + b) % P;
         2'd1:    return (a - b + P) % P;
         2'd2:    return (2 * a) % P;
         default: return (P - a) % P;
      endcase
   endfunction

   typedef struct { int data; int tag; } exp_t;
   exp_t sb[$];

   logic          mon_en = 1'b0;
   logic          stall_prev = 1'b0;
   logic [W-1:0]  data_prev;
   logic [TW-1:0] tag_prev;
   int            n_out = 0;

   always @(negedge clk) begin
      #1;
      if (mon_en && !rst) begin
         if (stall_prev) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", out_data, data_prev);
            chk("stall_hold_tag", out_tag, tag_prev);
         end
         if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
         if (in_valid && in_ready) sb.push_back('{model(in_op, int'(in_a), int'(in_b)), int'(in_tag)});
         if (out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) chk("out_when_empty", out_valid, 0);
            else begin
               chk("sb_data", out_data, sb[0].data);
               chk("sb_tag", out_tag, sb[0].tag);
               void'(sb.pop_front());
            end
         end
         stall_prev = out_valid && !out_ready;
         data_prev  = out_data;
         tag_prev   = out_tag;
      end
   end

   task automatic send_small(input logic [1:0] op, input int a, input int b, input int tag, output int lat);
      @(negedge clk);
      in_op = op; in_a = 16'(a); in_b = 16'(b); in_tag = 8'(tag); in_valid = 1'b1;
      #2 chk("idle_with_in_valid", idle, 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      #2 chk("idle_in_flight", idle, 0);
      lat = 1;
      while (!out_valid && lat < 40) begin @(negedge clk); #2; lat++; end
   endtask

   task automatic send_dflt(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
      @(negedge clk);
      d_in_op = op; d_in_a = a; d_in_b = b; d_in_tag = 8'h5a; d_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_in_valid = 1'b0;
      lat = 1;
      while (!d_out_valid && lat < 80) begin @(negedge clk); lat++; end
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin @(negedge clk); #2; t++; end
      chk(name, sb.size(), 0);
   endtask

   typedef struct { logic [1:0] op; int a; int b; int exp; } vec_t;
   vec_t tbl [12];

   initial begin
      int lat, n0, t;
      tbl[0]  = '{OP_ADD, 65520, 1, 0};
      tbl[1]  = '{OP_SUB, 3, 5, 65519};
      tbl[2]  = '{OP_NEG, 0, 77, 0};
      tbl[3]  = '{OP_NEG, 1, 0, 65520};
      tbl[4]  = '{OP_DBL, 65520, 9, 65519};
      tbl[5]  = '{OP_DBL, 40000, 0, 14479};
      tbl[6]  = '{OP_ADD, 100, 200, 300};
      tbl[7]  = '{OP_ADD, 65520, 65520, 65519};
      tbl[8]  = '{OP_SUB, 0, 65520, 1};
      tbl[9]  = '{OP_SUB, 65520, 65520, 0};
      tbl[10] = '{OP_DBL, 0, 5, 0};
      tbl[11] = '{OP_ADD, 32760, 32761, 0};

      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
      d_out_ready = 1'b1; d_in_valid = 1'b0; d_in_op = '0; d_in_a = '0; d_in_b = '0; d_in_tag = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_idle", idle, 1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_d_out_valid", d_out_valid, 0);
      chk("rst_d_idle", d_idle, 1);
      @(negedge clk) rst = 1'b0;
      mon_en = 1'b1;

      // Directed vectors, one at a time.
      for (int i = 0; i < 12; i++) begin
         send_small(tbl[i].op, tbl[i].a, tbl[i].b, 100 + i, lat);
         chk($sformatf("tbl%0d_lat", i), lat, LAT);
         chk($sformatf("tbl%0d_data", i), out_data, tbl[i].exp);
         chk($sformatf("tbl%0d_tag", i), out_tag, 100 + i);
      end
      drain("tbl_drain");

      // 64 back-to-back random ops, results must stream one per cycle.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 64; i++) begin
               @(negedge clk);
               in_valid = 1'b1;
               in_op  = 2'($urandom_range(0, 3));
               in_a   = 16'($urandom_range(0, P - 1));
               in_b   = 16'($urandom_range(0, P - 1));
               in_tag = 8'(i);
            end
            @(negedge clk) in_valid = 1'b0;
         end
         begin
            t = 0;
            while (n_out == n0 && t < 60) begin @(negedge clk); #2; t++; end
            t = 0;
            while (n_out < n0 + 64 && t < 200) begin @(negedge clk); #2; t++; end
            chk("stream_span", t, 63);
         end
      join
      chk("stream_count", n_out - n0, 64);
      drain("stream_drain");

      // Backpressure: out_ready low for 5 cycles mid-stream.
      n0 = n_out;
      fork
         begin
            int sent;
            logic fresh;
            sent = 0; fresh = 1'b1;
            while (sent < 24) begin
               @(negedge clk);
               if (fresh) begin
                  in_op  = 2'($urandom_range(0, 3));
                  in_a   = 16'($urandom_range(0, P - 1));
                  in_b   = 16'($urandom_range(0, P - 1));
                  in_tag = 8'(64 + sent);
               end
               in_valid = 1'b1;
               #1;
               fresh = in_ready;
               if (in_ready) sent++;
            end
            @(negedge clk) in_valid = 1'b0;
         end
         begin
            repeat (14) @(negedge clk);
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain("bp_drain");
      chk("bp_count", n_out - n0, 24);

      // Reset with three ops in flight.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_op = OP_ADD; in_a = 16'(i); in_b = 16'(1); in_tag = 8'(200 + i);
      end
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      sb.delete();
      @(negedge clk) rst = 1'b0;
      #2;
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_idle", idle, 1);
      chk("post_rst_in_ready", in_ready, 1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk); #2;
         chk("post_rst_quiet", out_valid, 0);
      end
      send_small(OP_ADD, 7, 8, 42, lat);
      chk("post_rst_lat", lat, LAT);
      chk("post_rst_data", out_data, 15);
      chk("post_rst_tag", out_tag, 42);
      drain("post_rst_drain");

      // Default-parameter instance.
      send_dflt(OP_DBL, PD - 1, '0, lat);
      chk("dflt_lat", lat, DLAT);
      chk("dflt_dbl_data", d_out_data, PD - 2);
      chk("dflt_tag", d_out_tag, 8'h5a);
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
      chk("dflt_err_clear", d_out_err, 0);
`endif
      send_dflt(OP_SUB, '0, 1, lat);
      chk("dflt_sub_data", d_out_data, PD - 1);
`ifdef ADD_SUB_MOD_RANGE_CHK_EN
      send_dflt(OP_ADD, PD, '0, lat);
      chk("dflt_err_set", d_out_err, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
